// File: rtl/waveform_buffer_reader_pkg.sv
// Shared definitions for the waveform buffer readout sequencer: default widths,
// header field placement and FSM state encoding.
package wvb_pkg;

    localparam int DEF_DATA_WIDTH = 85;
    localparam int DEF_ADR_WIDTH  = 10;
    localparam int DEF_HDR_WIDTH  = 104;
    localparam int DEF_RD_LATENCY = 2;

    // Start address sits at the bottom of the header, stop address right above it.
    localparam int HDR_START_LSB = 0;
    localparam int HDR_STOP_LSB  = HDR_START_LSB + DEF_ADR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic int hdr_stop_lsb(input int adr_width);
        return HDR_START_LSB + adr_width;
    endfunction

endpackage

// File: rtl/waveform_buffer_reader_if.sv
// Bundle of the header FIFO, BRAM read port, output stream and status signals
// around the waveform buffer reader.
interface waveform_buffer_reader_if
    import wvb_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P_ADR_WIDTH  = DEF_ADR_WIDTH,
    parameter int P_HDR_WIDTH  = DEF_HDR_WIDTH
) ();

    logic                    en;
    logic                    hdr_empty;
    logic [P_HDR_WIDTH-1:0]  hdr_data;
    logic                    hdr_rdreq;
    logic [P_ADR_WIDTH-1:0]  wvb_rd_addr;
    logic [P_DATA_WIDTH-1:0] wvb_data_in;
    logic [P_DATA_WIDTH-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_hdr;
    logic                    dout_last;
    logic [P_ADR_WIDTH-1:0]  rd_ptr;
    logic                    rd_done;
    logic                    busy;

    modport master (
        input  en, hdr_empty, hdr_data, wvb_data_in, dout_ready,
        output hdr_rdreq, wvb_rd_addr, dout, dout_valid, dout_hdr, dout_last,
               rd_ptr, rd_done, busy
    );

    modport slave (
        output en, hdr_empty, hdr_data, wvb_data_in, dout_ready,
        input  hdr_rdreq, wvb_rd_addr, dout, dout_valid, dout_hdr, dout_last,
               rd_ptr, rd_done, busy
    );

endinterface

// File: rtl/waveform_buffer_reader_out_fifo.sv
// Small register FIFO holding header/data words on their way to the downstream
// valid/ready port; the head entry stays put while the consumer stalls.
module wvb_out_fifo #(
    parameter int P_WIDTH = 87,
    parameter int P_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [P_WIDTH-1:0] push_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [P_WIDTH-1:0] out_data_o
);

    localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CNT_W = $clog2(P_DEPTH + 1);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = mem_q[rd_ptr_q];

    // The producer only pushes into a slot it already holds a credit for.
    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/waveform_buffer_reader.sv
// Readout sequencer: pops a header, streams it followed by the BRAM words from
// start to stop address, then reports the freed read pointer.
module waveform_buffer_reader
    import wvb_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P_ADR_WIDTH  = DEF_ADR_WIDTH,
    parameter int P_HDR_WIDTH  = DEF_HDR_WIDTH,
    parameter int P_RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    waveform_buffer_reader_if.master bus
);

    localparam int BUF_DEPTH = P_RD_LATENCY + 2;
    localparam int CRD_W     = $clog2(BUF_DEPTH + 1);
    localparam int ENT_W     = P_DATA_WIDTH + 2;
    localparam int STOP_LSB  = hdr_stop_lsb(P_ADR_WIDTH);

    state_e                 state_q, state_d;
    logic [P_HDR_WIDTH-1:0] hdr_q, hdr_d;
    logic [P_ADR_WIDTH-1:0] stop_q, stop_d;
    logic [P_ADR_WIDTH-1:0] addr_q, addr_d;
    logic [P_ADR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CRD_W-1:0]       credit_q, credit_d;
    logic                   rd_done_q, rd_done_d;

    logic             hdr_pop, hdr_push, issue, issue_last;
    logic             rd_vld, rd_last;
    logic             fifo_push, fifo_valid, fifo_pop;
    logic [ENT_W-1:0] fifo_wdata, fifo_rdata;
    logic             fifo_last;

    assign fifo_pop  = fifo_valid && bus.dout_ready;
    assign fifo_last = fifo_rdata[P_DATA_WIDTH];

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        stop_d     = stop_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_done_d  = 1'b0;
        hdr_pop    = 1'b0;
        hdr_push   = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.en && !bus.hdr_empty) begin
                    hdr_pop = 1'b1;
                    hdr_d   = bus.hdr_data;
                    addr_d  = bus.hdr_data[HDR_START_LSB +: P_ADR_WIDTH];
                    stop_d  = bus.hdr_data[STOP_LSB +: P_ADR_WIDTH];
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (credit_q != '0) begin
                    hdr_push = 1'b1;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                // Address wraps naturally at 2^P_ADR_WIDTH; stop is compared before the increment.
                if (credit_q != '0) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == stop_q) begin
                        issue_last = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (fifo_pop && fifo_last) begin
                    rd_ptr_d  = stop_q + 1'b1;
                    rd_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A slot is reserved when a read is issued, not when its data lands.
        credit_d = credit_q + CRD_W'(fifo_pop) - CRD_W'(issue || hdr_push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hdr_q     <= '0;
            stop_q    <= '0;
            addr_q    <= '0;
            rd_ptr_q  <= '0;
            rd_done_q <= 1'b0;
            credit_q  <= CRD_W'(BUF_DEPTH);
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            stop_q    <= stop_d;
            addr_q    <= addr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_done_q <= rd_done_d;
            credit_q  <= credit_d;
        end
    end

    // Valid/last tags travel alongside the BRAM pipeline so data is captured exactly when it appears.
    for (genvar gi = 0; gi < P_RD_LATENCY; gi++) begin : g_tag
        logic vld_q, last_q, vld_d, last_d;
        if (gi == 0) begin : g_head
            assign vld_d  = issue;
            assign last_d = issue_last;
        end else begin : g_tail
            assign vld_d  = g_tag[gi-1].vld_q;
            assign last_d = g_tag[gi-1].last_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end else begin
                vld_q  <= vld_d;
                last_q <= last_d;
            end
        end
    end

    assign rd_vld  = g_tag[P_RD_LATENCY-1].vld_q;
    assign rd_last = g_tag[P_RD_LATENCY-1].last_q;

    // Header and read data never collide: the previous waveform drained before HDR.
    assign fifo_push  = hdr_push || rd_vld;
    assign fifo_wdata = hdr_push ? {1'b1, 1'b0, P_DATA_WIDTH'(hdr_q)}
                                 : {1'b0, rd_last, bus.wvb_data_in};

    wvb_out_fifo #(
        .P_WIDTH (ENT_W),
        .P_DEPTH (BUF_DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .out_valid_o (fifo_valid),
        .out_ready_i (bus.dout_ready),
        .out_data_o  (fifo_rdata)
    );

    assign bus.hdr_rdreq   = hdr_pop;
    assign bus.wvb_rd_addr = addr_q;
    assign bus.dout        = fifo_rdata[P_DATA_WIDTH-1:0];
    assign bus.dout_last   = fifo_last;
    assign bus.dout_hdr    = fifo_rdata[P_DATA_WIDTH+1];
    assign bus.dout_valid  = fifo_valid;
    assign bus.rd_ptr      = rd_ptr_q;
    assign bus.rd_done     = rd_done_q;
    assign bus.busy        = (state_q != S_IDLE) || fifo_valid;

endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Directed bench for waveform_buffer_reader with header FIFO and 2-cycle BRAM models.
module tb_waveform_buffer_reader;

    localparam int DW = 85;
    localparam int AW = 10;
    localparam int HW = 104;

    typedef logic [DW+1:0] word_t;
    typedef struct {
        logic [AW-1:0] start;
        logic [AW-1:0] stop;
        logic [7:0]    tag;
        int            exp_n;
        logic [AW-1:0] exp_ptr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    waveform_buffer_reader_if bus ();

    waveform_buffer_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] wfun(input logic [AW-1:0] a);
        return {a, ~a, 65'h1_2345_6789_ABCD_EF01 ^ {55'd0, a}};
    endfunction

    function automatic logic [HW-1:0] mkhdr(input logic [AW-1:0] start, input logic [AW-1:0] stop,
                                            input logic [7:0] tag);
        logic [HW-1:0] h;
        h          = '0;
        h[AW-1:0]  = start;
        h[2*AW-1:AW] = stop;
        h[27:20]   = tag;
        h[84:77]   = ~tag;
        h[103:96]  = 8'hA5;
        return h;
    endfunction

    // Header FIFO model (first-word-fall-through)
    logic [HW-1:0] hdr_mem [16];
    logic [3:0]    hdr_cnt = 4'd0;
    logic [3:0]    hdr_rd  = 4'd0;
    assign bus.hdr_empty = (hdr_rd == hdr_cnt);
    assign bus.hdr_data  = hdr_mem[hdr_rd];
    always @(posedge clk) if (bus.hdr_rdreq) hdr_rd <= hdr_rd + 4'd1;

    // BRAM model: data for the address seen at edge N appears after edge N+1
    logic [AW-1:0] bram_a1;
    logic [DW-1:0] bram_q;
    always @(posedge clk) begin
        bram_a1 <= bus.wvb_rd_addr;
        bram_q  <= wfun(bram_a1);
    end
    assign bus.wvb_data_in = bram_q;

    bit rand_ready = 1'b0;
    always begin
        @(posedge clk);
        #1;
        bus.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: accepted words, their cycle, rd_done pulses, stall stability violations
    word_t         got_q[$];
    int            got_c[$];
    int            cyc      = 0;
    int            done_cnt = 0;
    logic [AW-1:0] last_ptr = '0;
    int            viol     = 0;
    logic          prev_stall = 1'b0;
    word_t         prev_word  = '0;
    always begin
        word_t w;
        @(negedge clk);
        cyc++;
        w = {bus.dout_hdr, bus.dout_last, bus.dout};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(bus.dout_valid === 1'b1 && w === prev_word)) viol++;
            if (bus.dout_valid && bus.dout_ready) begin
                got_q.push_back(w);
                got_c.push_back(cyc);
            end
            if (bus.rd_done) begin
                done_cnt++;
                last_ptr = bus.rd_ptr;
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_word  = w;
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_hdr(input logic [AW-1:0] start, input logic [AW-1:0] stop, input logic [7:0] tag);
        hdr_mem[hdr_cnt] = mkhdr(start, stop, tag);
        hdr_cnt          = hdr_cnt + 4'd1;
    endtask

    task automatic wait_done(input string nm, input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check(nm, done_cnt, target);
    endtask

    task automatic wait_words(input string nm, input int target, input int budget);
        int k = 0;
        while (got_q.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, 128'(got_q.size() >= target), 1);
    endtask

    task automatic check_wave(input string nm, input int base, input logic [AW-1:0] start,
                              input logic [AW-1:0] stop, input logic [7:0] tag, input int n);
        logic [HW-1:0] h;
        word_t         exp, act;
        logic [AW-1:0] a;
        h = mkhdr(start, stop, tag);
        for (int i = 0; i <= n; i++) begin
            if (i == 0) begin
                exp = {1'b1, 1'b0, h[DW-1:0]};
            end else begin
                a   = start + AW'(i - 1);
                exp = {1'b0, (i == n), wfun(a)};
            end
            act = (base + i < got_q.size()) ? got_q[base + i] : 'x;
            check($sformatf("%s_w%0d", nm, i), act, exp);
        end
    endtask

    initial begin
        vec_t       vecs[6];
        int         base;
        int         tgt;
        int         v0;
        logic [3:0] pre;

        vecs[0] = '{10'd10,   10'd13,   8'h11, 4,  10'd14};
        vecs[1] = '{10'd1022, 10'd1,    8'h12, 4,  10'd2};
        vecs[2] = '{10'd5,    10'd5,    8'h13, 1,  10'd6};
        vecs[3] = '{10'd1023, 10'd1023, 8'h14, 1,  10'd0};
        vecs[4] = '{10'd0,    10'd9,    8'h15, 10, 10'd10};
        vecs[5] = '{10'd1000, 10'd20,   8'h16, 45, 10'd21};

        rst_n  = 1'b0;
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_dout",  bus.dout, 0);
        check("rst_flags", {bus.dout_hdr, bus.dout_last}, 0);
        check("rst_rdreq", bus.hdr_rdreq, 0);
        check("rst_addr",  bus.wvb_rd_addr, 0);
        check("rst_ptr",   bus.rd_ptr, 0);
        check("rst_done",  bus.rd_done, 0);
        check("rst_busy",  bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.en = 1'b1;

        // Single waveforms, ready held high
        for (int v = 0; v < 6; v++) begin
            base = got_q.size();
            tgt  = done_cnt + 1;
            push_hdr(vecs[v].start, vecs[v].stop, vecs[v].tag);
            wait_done($sformatf("v%0d_done", v), tgt, 400);
            check($sformatf("v%0d_cnt", v), got_q.size() - base, vecs[v].exp_n + 1);
            check_wave($sformatf("v%0d", v), base, vecs[v].start, vecs[v].stop, vecs[v].tag, vecs[v].exp_n);
            check($sformatf("v%0d_ptr", v), last_ptr, vecs[v].exp_ptr);
            check($sformatf("v%0d_rate", v),
                  (base + vecs[v].exp_n < got_c.size()) ? got_c[base + vecs[v].exp_n] - got_c[base + 1] : -1,
                  vecs[v].exp_n - 1);
            check($sformatf("v%0d_busy", v), bus.busy, 0);
        end

        // Three queued headers under random backpressure
        rand_ready = 1'b1;
        base = got_q.size();
        tgt  = done_cnt + 3;
        v0   = viol;
        push_hdr(10'd700,  10'd705, 8'h21);
        push_hdr(10'd1020, 10'd3,   8'h22);
        push_hdr(10'd40,   10'd40,  8'h23);
        wait_done("rnd_done", tgt, 1500);
        check("rnd_cnt", got_q.size() - base, 18);
        check_wave("rnd_a", base,      10'd700,  10'd705, 8'h21, 6);
        check_wave("rnd_b", base + 7,  10'd1020, 10'd3,   8'h22, 8);
        check_wave("rnd_c", base + 16, 10'd40,   10'd40,  8'h23, 1);
        check("rnd_ptr", last_ptr, 41);
        check("rnd_stable", viol, v0);
        rand_ready = 1'b0;

        // Enable dropped mid-waveform
        base = got_q.size();
        tgt  = done_cnt + 1;
        pre  = hdr_cnt;
        push_hdr(10'd200, 10'd219, 8'h31);
        push_hdr(10'd300, 10'd302, 8'h32);
        wait_words("en_mid", base + 4, 200);
        bus.en = 1'b0;
        wait_done("en_done1", tgt, 400);
        repeat (10) @(negedge clk);
        check("en_hold_pop",  hdr_rd, pre + 4'd1);
        check("en_hold_cnt",  got_q.size() - base, 21);
        check("en_hold_busy", bus.busy, 0);
        check("en_hold_ptr",  bus.rd_ptr, 220);
        check_wave("en_a", base, 10'd200, 10'd219, 8'h31, 20);
        bus.en = 1'b1;
        wait_done("en_done2", tgt + 1, 400);
        check("en_cnt", got_q.size() - base, 25);
        check_wave("en_b", base + 21, 10'd300, 10'd302, 8'h32, 3);
        check("en_ptr", last_ptr, 303);

        // Reset during DATA, then a fresh waveform
        base = got_q.size();
        push_hdr(10'd400, 10'd429, 8'h41);
        wait_words("mid_data", base + 6, 200);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.dout_valid, 0);
        check("arst_dout",  bus.dout, 0);
        check("arst_flags", {bus.dout_hdr, bus.dout_last}, 0);
        check("arst_addr",  bus.wvb_rd_addr, 0);
        check("arst_ptr",   bus.rd_ptr, 0);
        check("arst_busy",  bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = got_q.size();
        tgt  = done_cnt + 1;
        push_hdr(10'd50, 10'd52, 8'h51);
        wait_done("post_done", tgt, 400);
        check("post_cnt", got_q.size() - base, 4);
        check_wave("post", base, 10'd50, 10'd52, 8'h51, 3);
        check("post_ptr", last_ptr, 53);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
